// File: rtl/histogram_accum_ctrl.sv
// ---------------------------------------------------------------------------
// histogram_accum_ctrl
//
// Purpose:
//   Runs one frame through an external single dual-address histogram RAM.
//   The RAM has a 1-cycle registered read and returns the pre-write value when
//   the same address is read and written in one cycle. A frame has three phases:
//     - clear every bin to zero,
//     - count one hit per pixel at full rate (read-modify-write with forwarding),
//     - stream every bin out over a valid/ready interface.
//
// Build option:
//   HIST_SAT_EN  when defined, a bin counter saturates at all-ones. When it is
//                undefined, a bin counter wraps to zero.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   start_i                 begin a frame (only honoured while idle)
//   busy_o, done_o          frame in progress / 1-cycle completion pulse
//   pix_valid_i/ready_o     pixel stream handshake
//   pix_data_i, pix_last_i  pixel bin index, last pixel of frame
//   bin_valid_o/ready_i     readout handshake
//   bin_data_o, bin_addr_o  bin count and its index
//   bin_last_o              marks bin C_DEPTH-1
//   ram_we_o, ram_waddr_o, ram_wdata_o, ram_raddr_o, ram_rdata_i
//                           histogram RAM write/read ports
// ---------------------------------------------------------------------------
module histogram_accum_ctrl #(
  parameter  int C_DATA_WIDTH = 16,
  parameter  int C_DEPTH      = 256,
  localparam int C_AW         = $clog2(C_DEPTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  input  logic                    pix_valid_i,
  output logic                    pix_ready_o,
  input  logic [C_AW-1:0]         pix_data_i,
  input  logic                    pix_last_i,
  output logic                    bin_valid_o,
  input  logic                    bin_ready_i,
  output logic [C_DATA_WIDTH-1:0] bin_data_o,
  output logic [C_AW-1:0]         bin_addr_o,
  output logic                    bin_last_o,
  output logic                    ram_we_o,
  output logic [C_AW-1:0]         ram_waddr_o,
  output logic [C_DATA_WIDTH-1:0] ram_wdata_o,
  output logic [C_AW-1:0]         ram_raddr_o,
  input  logic [C_DATA_WIDTH-1:0] ram_rdata_i
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ACCUM   = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_RD_REQ  = 3'd4,
    ST_RD_DATA = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  localparam logic [C_AW-1:0]         C_LAST_BIN = C_AW'(C_DEPTH - 1);
  localparam logic [C_AW-1:0]         C_AW_ONE   = C_AW'(1);
  localparam logic [C_DATA_WIDTH-1:0] C_DW_ONE   = C_DATA_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [C_AW-1:0]         cnt_q, cnt_d;          // clear index, then readout bin index
  logic                    s1_valid_q, s1_valid_d;
  logic [C_AW-1:0]         s1_addr_q, s1_addr_d;
  logic                    wr_valid_q, wr_valid_d; // an S1 write happened last cycle
  logic [C_AW-1:0]         wr_addr_q, wr_addr_d;
  logic [C_DATA_WIDTH-1:0] last_wdata_q, last_wdata_d;

  logic                    accept_s;
  logic                    fwd_s;
  logic [C_DATA_WIDTH-1:0] old_s;
  logic [C_DATA_WIDTH-1:0] new_s;

  // Bin increment; the overflow behaviour is a build-time choice.
  function automatic logic [C_DATA_WIDTH-1:0] bin_inc(input logic [C_DATA_WIDTH-1:0] v);
`ifdef HIST_SAT_EN
    return (v == {C_DATA_WIDTH{1'b1}}) ? v : (v + C_DW_ONE);
`else
    return v + C_DW_ONE;
`endif
  endfunction

  assign accept_s = (state_q == ST_ACCUM) && pix_valid_i;

  // The RAM returned the value from before last cycle's write to the same bin,
  // so the freshly written count has to be taken from the local copy.
  assign fwd_s = wr_valid_q && (wr_addr_q == s1_addr_q);
  assign old_s = fwd_s ? last_wdata_q : ram_rdata_i;
  assign new_s = bin_inc(old_s);

  // State, counter and pipeline registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_addr_q    <= '0;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      last_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      s1_valid_q   <= s1_valid_d;
      s1_addr_q    <= s1_addr_d;
      wr_valid_q   <= wr_valid_d;
      wr_addr_q    <= wr_addr_d;
      last_wdata_q <= last_wdata_d;
    end
  end

  // Accumulate pipeline next-state: S0 accept feeds S1, S1 write feeds forwarding.
  always_comb begin
    s1_valid_d   = accept_s;
    s1_addr_d    = s1_addr_q;
    wr_valid_d   = s1_valid_q;
    wr_addr_d    = s1_addr_q;
    last_wdata_d = last_wdata_q;
    if (accept_s) begin
      s1_addr_d = pix_data_i;
    end else begin
      s1_addr_d = s1_addr_q;
    end
    if (s1_valid_q) begin
      last_wdata_d = new_s;
    end else begin
      last_wdata_d = last_wdata_q;
    end
  end

  // Frame sequencer next-state and all outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_o      = (state_q != ST_IDLE);
    done_o      = 1'b0;
    pix_ready_o = 1'b0;
    bin_valid_o = 1'b0;
    bin_data_o  = '0;
    bin_addr_o  = '0;
    bin_last_o  = 1'b0;
    ram_raddr_o = '0;
    // S1 writes only exist in ACCUM/DRAIN, so they never collide with CLEAR.
    ram_we_o    = s1_valid_q;
    ram_waddr_o = s1_valid_q ? s1_addr_q : '0;
    ram_wdata_o = s1_valid_q ? new_s : '0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CLEAR: begin
        ram_we_o    = 1'b1;
        ram_waddr_o = cnt_q;
        ram_wdata_o = '0;
        if (cnt_q == C_LAST_BIN) begin
          state_d = ST_ACCUM;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + C_AW_ONE;
        end
      end

      ST_ACCUM: begin
        pix_ready_o = 1'b1;
        ram_raddr_o = pix_data_i;
        if (accept_s && pix_last_i) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_ACCUM;
        end
      end

      ST_DRAIN: begin
        cnt_d   = '0;
        state_d = ST_RD_REQ;
      end

      ST_RD_REQ: begin
        ram_raddr_o = cnt_q;
        state_d     = ST_RD_DATA;
      end

      ST_RD_DATA: begin
        // Read address is held, so the RAM output stays stable while stalled.
        ram_raddr_o = cnt_q;
        bin_valid_o = 1'b1;
        bin_data_o  = ram_rdata_i;
        bin_addr_o  = cnt_q;
        bin_last_o  = (cnt_q == C_LAST_BIN);
        if (bin_ready_i) begin
          if (cnt_q == C_LAST_BIN) begin
            state_d = ST_DONE;
          end else begin
            cnt_d   = cnt_q + C_AW_ONE;
            state_d = ST_RD_REQ;
          end
        end else begin
          state_d = ST_RD_DATA;
        end
      end

      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_histogram_accum_ctrl.sv
// ---------------------------------------------------------------------------
// tb_histogram_accum_ctrl
//
// Drives two controllers from the same stimulus: a 16-bit-counter instance and
// a 4-bit-counter instance (to reach counter overflow quickly). Each has its
// own behavioural RAM with registered, read-before-write output. Pixel frames
// and expected bin counts come from tables filled at the top of the test;
// reset, clear, stall and mid-frame reset are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_histogram_accum_ctrl;

  localparam int AW    = 8;
  localparam int DEPTH = 256;

  typedef struct {
    int         frame;
    logic [7:0] pix;
    int         gap;   // idle cycles after this pixel
    logic       last;
  } pix_vec_t;

  typedef struct {
    int frame;
    int addr;
    int count;         // true count; 4-bit expectation derived from it
  } exp_vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_last;
  logic        bin_ready;

  logic        busy, done, pix_ready, bin_valid, bin_last, we;
  logic [7:0]  bin_addr, waddr, raddr;
  logic [15:0] bin_data, wdata, rdata;

  logic        busy4, done4, pix_ready4, bin_valid4, bin_last4, we4;
  logic [7:0]  bin_addr4, waddr4, raddr4;
  logic [3:0]  bin_data4, wdata4, rdata4;

  logic [15:0] mem16 [DEPTH];
  logic [3:0]  mem4  [DEPTH];

  pix_vec_t pix_tab[$];
  exp_vec_t exp_tab[$];

  int n_checks = 0;
  int n_pass   = 0;

  histogram_accum_ctrl #(.C_DATA_WIDTH(16), .C_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done),
    .pix_valid_i(pix_valid), .pix_ready_o(pix_ready), .pix_data_i(pix_data),
    .pix_last_i(pix_last), .bin_valid_o(bin_valid), .bin_ready_i(bin_ready),
    .bin_data_o(bin_data), .bin_addr_o(bin_addr), .bin_last_o(bin_last),
    .ram_we_o(we), .ram_waddr_o(waddr), .ram_wdata_o(wdata),
    .ram_raddr_o(raddr), .ram_rdata_i(rdata)
  );

  histogram_accum_ctrl #(.C_DATA_WIDTH(4), .C_DEPTH(DEPTH)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy4), .done_o(done4),
    .pix_valid_i(pix_valid), .pix_ready_o(pix_ready4), .pix_data_i(pix_data),
    .pix_last_i(pix_last), .bin_valid_o(bin_valid4), .bin_ready_i(bin_ready),
    .bin_data_o(bin_data4), .bin_addr_o(bin_addr4), .bin_last_o(bin_last4),
    .ram_we_o(we4), .ram_waddr_o(waddr4), .ram_wdata_o(wdata4),
    .ram_raddr_o(raddr4), .ram_rdata_i(rdata4)
  );

  always #5 clk = ~clk;

  // Behavioural RAMs: registered read returning the pre-write value.
  always @(posedge clk) begin
    if (we) mem16[waddr] <= wdata;
    rdata <= mem16[raddr];
    if (we4) mem4[waddr4] <= wdata4;
    rdata4 <= mem4[raddr4];
  end

  task automatic check(input string name, input logic ok, input string detail);
    n_checks++;
    if (ok === 1'b1) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  function automatic int exp4(input int c);
`ifdef HIST_SAT_EN
    return (c > 15) ? 15 : c;
`else
    return c % 16;
`endif
  endfunction

  function automatic logic outs_zero();
    return !(busy | done | pix_ready | bin_valid | bin_last | we | (|bin_addr) | (|bin_data) |
             (|waddr) | (|wdata) | (|raddr) |
             busy4 | done4 | pix_ready4 | bin_valid4 | bin_last4 | we4 | (|bin_addr4) |
             (|bin_data4) | (|waddr4) | (|wdata4) | (|raddr4));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start and verify the full CLEAR sweep on both instances.
  task automatic start_frame();
    int errs;
    errs = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy && busy4,
          $sformatf("busy=%0b busy4=%0b, want 1", busy, busy4));
    for (int i = 0; i < DEPTH; i++) begin
      if (!(we && waddr == 8'(i) && wdata == 16'h0 && !pix_ready &&
            we4 && waddr4 == 8'(i) && wdata4 == 4'h0 && !pix_ready4)) begin
        if (errs == 0)
          $display("FAIL clear_write: cycle %0d we=%0b waddr=%0d wdata=%0h ready=%0b, want we=1 waddr=%0d wdata=0 ready=0",
                   i, we, waddr, wdata, pix_ready, i);
        errs++;
      end
      tick();
    end
    check("clear_writes", errs == 0, $sformatf("%0d bad clear cycles, want 0", errs));
    check("ready_after_clear", pix_ready && pix_ready4 && !we,
          $sformatf("pix_ready=%0b we=%0b, want ready=1 we=0", pix_ready, we));
  endtask

  task automatic send_pixels(input int f);
    int n;
    foreach (pix_tab[i]) begin
      if (pix_tab[i].frame == f) begin
        pix_valid = 1'b1;
        pix_data  = pix_tab[i].pix;
        pix_last  = pix_tab[i].last;
        n = 0;
        while (!pix_ready && n < 20) begin
          tick();
          n++;
        end
        check("pix_ready_wait", pix_ready, $sformatf("pix_ready=%0b for pixel %0d, want 1", pix_ready, i));
        tick();
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        repeat (pix_tab[i].gap) tick();
      end
    end
  endtask

  task automatic readout(input int f, input int stall_bin);
    int exp_cnt[DEPTH];
    int n, e, e4;
    foreach (exp_cnt[i]) exp_cnt[i] = 0;
    foreach (exp_tab[i]) if (exp_tab[i].frame == f) exp_cnt[exp_tab[i].addr] = exp_tab[i].count;
    for (int b = 0; b < DEPTH; b++) begin
      n = 0;
      while (!bin_valid && n < 10) begin
        tick();
        n++;
      end
      e  = exp_cnt[b];
      e4 = exp4(e);
      check($sformatf("f%0d_bin%0d", f, b),
            bin_valid && bin_valid4 && bin_addr == 8'(b) && bin_data == 16'(e) &&
            bin_data4 == 4'(e4) && bin_last == (b == DEPTH - 1) && bin_last4 == (b == DEPTH - 1) &&
            !pix_ready && !we && busy,
            $sformatf("valid=%0b addr=%0d data=%0d data4=%0d last=%0b, want valid=1 addr=%0d data=%0d data4=%0d last=%0b",
                      bin_valid, bin_addr, bin_data, bin_data4, bin_last, b, e, e4, b == DEPTH - 1));
      if (!bin_valid) return;
      if (b == stall_bin) begin
        // start_i while busy must be ignored.
        start = 1'b1;
        for (int k = 0; k < 5; k++) begin
          tick();
          check($sformatf("stall_%0d", k),
                bin_valid && bin_addr == 8'(b) && bin_data == 16'(e) && bin_data4 == 4'(e4) && busy,
                $sformatf("valid=%0b addr=%0d data=%0d busy=%0b, want 1/%0d/%0d/1",
                          bin_valid, bin_addr, bin_data, busy, b, e));
        end
        start = 1'b0;
      end
      bin_ready = 1'b1;
      tick();
      bin_ready = 1'b0;
    end
    check("done_pulse", done && done4 && busy && !bin_valid,
          $sformatf("done=%0b done4=%0b busy=%0b valid=%0b, want 1/1/1/0", done, done4, busy, bin_valid));
    tick();
    check("idle_after_done", !done && !busy && !busy4,
          $sformatf("done=%0b busy=%0b, want 0/0", done, busy));
  endtask

  task automatic run_frame(input int f, input int stall_bin);
    start_frame();
    send_pixels(f);
    readout(f, stall_bin);
  endtask

  initial begin
    // Frame 1: four hits on bin 5 back-to-back (forwarding chain).
    for (int i = 0; i < 4; i++) pix_tab.push_back('{1, 8'd5, 0, i == 3});
    exp_tab.push_back('{1, 5, 4});
    // Frame 2: 3,7,3,7 with 1-cycle gaps, then 3,3 back-to-back.
    pix_tab.push_back('{2, 8'd3, 1, 1'b0});
    pix_tab.push_back('{2, 8'd7, 1, 1'b0});
    pix_tab.push_back('{2, 8'd3, 1, 1'b0});
    pix_tab.push_back('{2, 8'd7, 1, 1'b0});
    pix_tab.push_back('{2, 8'd3, 0, 1'b0});
    pix_tab.push_back('{2, 8'd3, 0, 1'b1});
    exp_tab.push_back('{2, 3, 4});
    exp_tab.push_back('{2, 7, 2});
    // Frame 3: twenty hits on bin 1 (overflows the 4-bit instance).
    for (int i = 0; i < 20; i++) pix_tab.push_back('{3, 8'd1, 0, i == 19});
    exp_tab.push_back('{3, 1, 20});
    // Frame 5 (after a mid-frame reset): single pixel that is also last.
    pix_tab.push_back('{5, 8'd4, 0, 1'b1});
    exp_tab.push_back('{5, 4, 1});

    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = 8'd0; pix_last = 1'b0; bin_ready = 1'b0;
    #1;
    check("reset_outputs", outs_zero(), "some output nonzero during reset, want all 0");
    tick();
    rst = 1'b0;
    tick();
    check("idle_no_start", !busy && !pix_ready, $sformatf("busy=%0b ready=%0b, want 0/0", busy, pix_ready));

    run_frame(1, 9);
    run_frame(2, -1);
    run_frame(3, -1);

    // Mid-ACCUM reset: counts of bin 2 in progress must be discarded.
    start_frame();
    pix_valid = 1'b1;
    pix_data  = 8'd2;
    repeat (3) tick();
    check("accum_writing", we && waddr == 8'd2, $sformatf("we=%0b waddr=%0d, want 1/2", we, waddr));
    rst = 1'b1;
    #1;
    check("midframe_reset_outputs", outs_zero(), "some output nonzero after mid-frame reset, want all 0");
    tick();
    rst = 1'b0;
    pix_valid = 1'b0;
    pix_data  = 8'd0;
    tick();
    check("idle_after_reset", !busy && !pix_ready, $sformatf("busy=%0b ready=%0b, want 0/0", busy, pix_ready));
    run_frame(5, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
